dualport_ram_be: RTL and testbench

Single-clock, parametrised dual-port RAM: one write port with per-byte write enables, one read port with a registered, handshaked output. After every reset it clears its own contents through a counter-driven sweep and flags readiness. It is the storage core for single-clock FIFOs and buffers where a combinational read path and uninitialised contents are not acceptable.

---
 rtl/dualport_ram_be.sv | 112 +++++++++++
 tb/tb_dualport_ram_be.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dualport_ram_be.sv
`default_nettype none
// ============================================================================
// Module   : dualport_ram_be
// Purpose  : Single-clock dual-port RAM with one byte-enabled write port and
//            one registered read port with a one-cycle r_valid strobe. After
//            every reset the array is zeroed by a counter-driven sweep and
//            init_busy stays high until the sweep has finished.
// Options  : DPRAM_BYPASS_EN - when defined, a read and a write to the same
//            address on the same edge return the merged word (written lanes
//            from w_data, other lanes from memory). When undefined, the read
//            returns the old memory word (read-before-write).
// Revision : 1.0 - initial release
// ============================================================================
module dualport_ram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_W     = 8,
  parameter int DEPTH      = 16,
  localparam int NB        = DATA_WIDTH / BYTE_W,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [AW-1:0]         w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [NB-1:0]         w_be,
  input  logic                  r_en,
  input  logic [AW-1:0]         r_addr,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  init_busy
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e                  state_q;
  logic [AW-1:0]           clr_cnt_q;
  logic                    r_valid_q;
  logic [DATA_WIDTH-1:0]   r_data_q;
  logic [DATA_WIDTH-1:0]   r_data_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

`ifdef DPRAM_BYPASS_EN
  logic collide_d;
  assign collide_d = w_en && (w_addr == r_addr);

  // Merge the in-flight write into the read word lane by lane on a collision.
  for (genvar l = 0; l < NB; l++) begin : g_lane
    assign r_data_d[l*BYTE_W +: BYTE_W] = (collide_d && w_be[l])
                                        ? w_data[l*BYTE_W +: BYTE_W]
                                        : mem_q[r_addr][l*BYTE_W +: BYTE_W];
  end
`else
  // Plain read of the stored word; a same-edge write lands after this sample.
  assign r_data_d = mem_q[r_addr];
`endif

  // Control FSM: clear sweep sequencing and the registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          r_valid_q <= 1'b0;
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == AW'(DEPTH - 1)) begin
            state_q <= READY;
          end
        end
        READY: begin
          r_valid_q <= r_en;
          if (r_en) begin
            r_data_q <= r_data_d;
          end
        end
        default: begin
          state_q   <= CLEAR;
          clr_cnt_q <= '0;
          r_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: zeroed by the sweep, then byte-lane writes in READY.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (w_en) begin
        for (int i = 0; i < NB; i++) begin
          if (w_be[i]) begin
            mem_q[w_addr][i*BYTE_W +: BYTE_W] <= w_data[i*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

  assign r_data    = r_data_q;
  assign r_valid   = r_valid_q;
  assign init_busy = (state_q == CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_dualport_ram_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_dualport_ram_be
// Purpose  : Self-checking bench for dualport_ram_be (DEPTH=16, 32-bit words,
//            4 byte lanes). Honours DPRAM_BYPASS_EN for collision results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dualport_ram_be;

`ifdef DPRAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_en = 1'b0;
  logic [3:0]  w_addr = '0;
  logic [31:0] w_data = '0;
  logic [3:0]  w_be = '0;
  logic        r_en = 1'b0;
  logic [3:0]  r_addr = '0;
  logic [31:0] r_data;
  logic        r_valid;
  logic        init_busy;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] model_mem [16];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  dualport_ram_be #(
    .DATA_WIDTH(32),
    .BYTE_W(8),
    .DEPTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .w_en(w_en),
    .w_addr(w_addr),
    .w_data(w_data),
    .w_be(w_be),
    .r_en(r_en),
    .r_addr(r_addr),
    .r_data(r_data),
    .r_valid(r_valid),
    .init_busy(init_busy)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [3:0]  ra;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one READY-state cycle, then apply it to the DUT.
  task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic re, input logic [3:0] ra,
                      output logic ev, output logic [31:0] ed);
    logic [31:0] word;
    word = model_mem[ra];
    if (BYP && we && (wa == ra)) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) word[l*8 +: 8] = wd[l*8 +: 8];
      end
    end
    ev = re;
    ed = re ? word : last_rd;
    last_rd = ed;
    if (we) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) model_mem[wa][l*8 +: 8] = wd[l*8 +: 8];
      end
    end
    w_en = we; w_addr = wa; w_data = wd; w_be = be;
    r_en = re; r_addr = ra;
    tick();
  endtask

  task automatic model_reset();
    for (int a = 0; a < 16; a++) model_mem[a] = '0;
    last_rd = '0;
  endtask

  task automatic read_all_zero(input string tag);
    logic        ev;
    logic [31:0] ed;
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, a[3:0], ev, ed);
      check($sformatf("%s_valid[%0d]", tag, a), {31'd0, r_valid}, {31'd0, ev});
      check($sformatf("%s_data[%0d]", tag, a), r_data, 32'd0);
    end
    step(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, ev, ed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ev;
    logic [31:0] ed;
    logic [31:0] coll;
    logic        we, re;
    logic [3:0]  wa, ra, be;
    logic [31:0] wd;

    coll = BYP ? 32'hAABB3344 : 32'h11223344;
    tbl.push_back('{1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, 4'd0, 1'b0, 32'h00000000});
    tbl.push_back('{1'b1, 4'd3, 32'h000000AA, 4'h1, 1'b0, 4'd0, 1'b0, 32'h00000000});
    tbl.push_back('{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd3, 1'b1, 32'hDEADBEAA});
    tbl.push_back('{1'b1, 4'd3, 32'hFFFFFFFF, 4'h0, 1'b1, 4'd3, 1'b1, 32'hDEADBEAA});
    tbl.push_back('{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd3, 1'b1, 32'hDEADBEAA});
    tbl.push_back('{1'b1, 4'd5, 32'h11223344, 4'hF, 1'b0, 4'd0, 1'b0, 32'hDEADBEAA});
    tbl.push_back('{1'b1, 4'd5, 32'hAABBCCDD, 4'hC, 1'b1, 4'd5, 1'b1, coll});
    tbl.push_back('{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd5, 1'b1, 32'hAABB3344});
    tbl.push_back('{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b0, 4'd0, 1'b0, 32'hAABB3344});
    tbl.push_back('{1'b1, 4'd0, 32'h01010101, 4'hF, 1'b0, 4'd0, 1'b0, 32'hAABB3344});
    tbl.push_back('{1'b1, 4'd1, 32'h02020202, 4'hF, 1'b0, 4'd0, 1'b0, 32'hAABB3344});
    tbl.push_back('{1'b1, 4'd2, 32'h03030303, 4'hF, 1'b0, 4'd0, 1'b0, 32'hAABB3344});
    tbl.push_back('{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd0, 1'b1, 32'h01010101});
    tbl.push_back('{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd1, 1'b1, 32'h02020202});
    tbl.push_back('{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b1, 4'd2, 1'b1, 32'h03030303});
    tbl.push_back('{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b0, 4'd0, 1'b0, 32'h03030303});
    tbl.push_back('{1'b0, 4'd0, 32'h00000000, 4'h0, 1'b0, 4'd0, 1'b0, 32'h03030303});

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    check("rst_r_valid", {31'd0, r_valid}, 32'd0);
    check("rst_r_data", r_data, 32'd0);
    check("rst_init_busy", {31'd0, init_busy}, 32'd1);

    // Sweep length after release: busy through edge 15, low after edge 16.
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("sweep1_busy[%0d]", k), {31'd0, init_busy}, (k < 16) ? 32'd1 : 32'd0);
    end
    model_reset();
    read_all_zero("post_clear");

    // Directed vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].ra, ev, ed);
      check($sformatf("tbl_valid[%0d]", i), {31'd0, r_valid}, {31'd0, tbl[i].ev});
      check($sformatf("tbl_data[%0d]", i), r_data, tbl[i].ed);
    end

    // Randomised traffic against the reference model, biased toward collisions.
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      step(we, wa, wd, be, re, ra, ev, ed);
      check($sformatf("rnd_valid[%0d]", i), {31'd0, r_valid}, {31'd0, ev});
      check($sformatf("rnd_data[%0d]", i), r_data, ed);
    end

    // Fill every word with nonzero data, then reset mid-sweep.
    for (int a = 0; a < 16; a++) begin
      step(1'b1, a[3:0], 32'hC0DE0000 + 32'(a) + 32'd1, 4'hF, 1'b0, 4'd0, ev, ed);
    end
    w_en = 1'b0; r_en = 1'b0;
    rst = 1'b1;
    tick();
    check("rst2_r_data", r_data, 32'd0);
    check("rst2_busy", {31'd0, init_busy}, 32'd1);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("partial_busy[%0d]", k), {31'd0, init_busy}, 32'd1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // Requests during the restarted sweep must be ignored.
    w_en = 1'b1; w_addr = 4'd9; w_data = 32'hFFFFFFFF; w_be = 4'hF;
    r_en = 1'b1; r_addr = 4'd9;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("sweep2_busy[%0d]", k), {31'd0, init_busy}, (k < 16) ? 32'd1 : 32'd0);
      check($sformatf("sweep2_valid[%0d]", k), {31'd0, r_valid}, 32'd0);
    end
    model_reset();
    read_all_zero("post_restart");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
